wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-port arbiter for the register file in the 5-stage pipeline. It merges the writeback stream from the MEM/WB pipeline register with results from the multi-cycle multiply/divide unit (MDU), and drives the single register-file write port. The MEM/WB stream always has priority. MDU results wait in a small FIFO until the port is idle. The block also reports pending-destination hazards and a backpressure stall to the pipeline controller.

## Interface

Parameters:
- DEPTH, 2: MDU result FIFO entries; power of two, ≥2.
- CW, 2: width of q_count, equal to log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- wb_reg_write  in  1  MEM/WB write enable.
- wb_mem_to_reg  in  1  1 selects wb_read_data, 0 selects wb_alu_res.
- wb_rd  in  5  MEM/WB destination register.
- wb_read_data  in  32  memory load data.
- wb_alu_res  in  32  ALU result.
- mdu_valid  in  1  MDU offers a result.
- mdu_ready  out  1  arbiter accepts the MDU result this cycle.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- chk_rs, chk_rt  in  5 each  ID-stage source registers to check.
- pend_hit  out  1  a buffered MDU result targets chk_rs or chk_rt.
- pipe_stall  out  1  FIFO full; pipeline must insert a bubble.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- q_count  out  CW  FIFO occupancy, including killed entries.

## Operation

- Request definition: wb_req = wb_reg_write && (wb_rd != 0).
- WB data mux: wb_data = wb_mem_to_reg ? wb_read_data : wb_alu_res.
- MDU handshake: mdu_ready = (q_count < DEPTH).
  - mdu_ready depends only on registered count and is never combinationally dependent on mdu_valid.
  - Transfer occurs when mdu_valid && mdu_ready.
  - A transferred result with mdu_rd == 0 is dropped and not enqueued.
- FIFO entry contents: {live, rd[4:0], data[31:0]}. Circular buffer with head/tail pointers and a count.
- Write-port grant, evaluated in priority order each cycle:
  1. wb_req: write wb_rd/wb_data; FIFO does not pop.
  2. Otherwise, if FIFO is non-empty, pop the head. If the head is live, write its rd/data. If it is killed, rf_we=0 but the slot is still consumed.
  3. Otherwise, rf_we=0.
- Kill rule (WAW): on a wb_req cycle, every stored entry with rd == wb_rd has live cleared.
  - An MDU result enqueued in that same cycle is not killed. The arriving MDU result counts as younger.
- No bypass: an accepted MDU result reaches rf_we no earlier than the cycle after acceptance.
- Push and pop in the same cycle are allowed whenever q_count < DEPTH; count is unchanged.
- pend_hit (combinational): any live stored entry with rd != 0 and rd == chk_rs or rd == chk_rt.
- pipe_stall (combinational from registered count): q_count == DEPTH.
  - The controller responds by forcing wb_reg_write=0, which frees the port so the FIFO can drain.

## Timing

- Reset (asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, q_count=0, all live bits=0, head=tail=0.
  - Consequently mdu_ready=1, pipe_stall=0, pend_hit=0.
- Reset asserted mid-operation discards all buffered MDU results; no write is issued for them.
- Latency: wb inputs at edge N produce rf_* valid after edge N+1, i.e. one register stage.
  - MDU minimum latency: accepted at edge N, written at rf_* after edge N+2 when the port is idle.
- Full boundary: with q_count == DEPTH, mdu_ready=0 even if a pop occurs this cycle; the MDU holds its result.
- Empty boundary: with no wb_req and q_count == 0, rf_we=0.
  - A result accepted this cycle is not written this cycle.
- Pointer wrap: head and tail wrap modulo DEPTH.
  - q_count saturates at exactly DEPTH and never exceeds it.
  - q_count never underflows: no pop is issued when the FIFO is empty.
- Ordering: MDU results retire in acceptance order. Killed entries retire silently in their original position.

## Test plan

- WB only: wb_reg_write=1, wb_rd=5, wb_mem_to_reg=1, wb_read_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
  - Repeat with wb_rd=0 -> rf_we=0.
- MDU idle port: mdu_valid for one cycle, rd=9, data=0x12345678, no WB -> q_count=1 for one cycle, then rf_we=1, rf_waddr=9, rf_wdata=0x12345678, then q_count=0.
- Contention and fill: continuous WB writes while the MDU pushes 3 results (DEPTH=2) -> after 2 accepts, mdu_ready=0 and pipe_stall=1. Drop wb_reg_write for 3 cycles -> MDU results written in acceptance order, then pipe_stall=0.
- WAW kill: buffered live entry rd=7; WB writes rd=7 -> entry killed and pend_hit for chk_rs=7 goes to 0. On a later idle cycle, the entry pops with rf_we=0 and q_count decrements.
- Hazard check: buffered rd=3 and rd=4; chk_rs=4, chk_rt=10 -> pend_hit=1. chk_rs=0, chk_rt=11 -> pend_hit=0.
- Async reset mid-run with 2 entries buffered -> outputs clear immediately without a clock edge: q_count=0, mdu_ready=1, and no write of the discarded entries.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the MEM/WB writeback stream with buffered MDU
// results onto the single register-file write port. MEM/WB always wins;
// MDU results wait in a small circular FIFO and drain when the port is idle.
// Same-register writes from MEM/WB kill older buffered MDU results (WAW),
// which then retire silently in their original position.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_reg_write,
  input  logic          wb_mem_to_reg,
  input  logic [4:0]    wb_rd,
  input  logic [31:0]   wb_read_data,
  input  logic [31:0]   wb_alu_res,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_rd,
  input  logic [31:0]   mdu_data,
  input  logic [4:0]    chk_rs,
  input  logic [4:0]    chk_rt,
  output logic          pend_hit,
  output logic          pipe_stall,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic [CW-1:0] q_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [DEPTH-1:0] live;
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic        wb_req;
  logic        push;
  logic        pop;
  logic [31:0] wb_data;

  // Request decode, data mux and FIFO handshake, all from registered count
  always_comb begin
    wb_req     = wb_reg_write && (wb_rd != 5'd0);
    wb_data    = wb_mem_to_reg ? wb_read_data : wb_alu_res;
    mdu_ready  = (q_count < CW'(DEPTH));
    pipe_stall = (q_count == CW'(DEPTH));
    push       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop        = !wb_req && (q_count != '0);
  end

  // Hazard check: any live buffered result targeting an ID-stage source
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (rd_mem[i] != 5'd0) &&
          ((rd_mem[i] == chk_rs) || (rd_mem[i] == chk_rt)))
        pend_hit = 1'b1;
    end
  end

  // FIFO control: pointers, occupancy and live bits (kill before push so the
  // result arriving this cycle is treated as younger than the WB write)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
      live    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_req && (rd_mem[i] == wb_rd))
          live[i] <= 1'b0;
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + AW'(1);
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + AW'(1);
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO payload storage; validity is tracked by the live bits, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= mdu_rd;
      data_mem[tail] <= mdu_data;
    end
  end

  // Registered write port: MEM/WB first, otherwise the popped head entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (wb_req) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end else if (pop) begin
      rf_we    <= live[head];
      rf_waddr <= rd_mem[head];
      rf_wdata <= data_mem[head];
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based model tracks the
// buffered MDU results and the expected write port; a compare process checks
// every cycle, and directed scenarios pin key values with literals.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wb_reg_write = 1'b0;
  logic          wb_mem_to_reg = 1'b0;
  logic [4:0]    wb_rd = 5'd0;
  logic [31:0]   wb_read_data = 32'd0;
  logic [31:0]   wb_alu_res = 32'd0;
  logic          mdu_valid = 1'b0;
  logic          mdu_ready;
  logic [4:0]    mdu_rd = 5'd0;
  logic [31:0]   mdu_data = 32'd0;
  logic [4:0]    chk_rs = 5'd0;
  logic [4:0]    chk_rt = 5'd0;
  logic          pend_hit;
  logic          pipe_stall;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] q_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          exp_we = 1'b0;
  logic [4:0]  exp_waddr = 5'd0;
  logic [31:0] exp_wdata = 32'd0;

  wb_port_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_read_data(wb_read_data), .wb_alu_res(wb_alu_res),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .chk_rs(chk_rs), .chk_rt(chk_rt),
    .pend_hit(pend_hit), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic bit model_pend(input logic [4:0] rs, input logic [4:0] rt);
    bit hit = 1'b0;
    foreach (mq[i])
      if (mq[i].live && mq[i].rd != 5'd0 && (mq[i].rd == rs || mq[i].rd == rt))
        hit = 1'b1;
    return hit;
  endfunction

  // Model: arbitration at each rising edge, cleared by async reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_we = 1'b0;
      exp_waddr = 5'd0;
      exp_wdata = 32'd0;
    end else begin
      bit   req;
      bit   accept;
      ent_t e;
      req    = wb_reg_write && (wb_rd != 5'd0);
      accept = mdu_valid && (mq.size() < DEPTH) && (mdu_rd != 5'd0);
      if (req) begin
        exp_we    = 1'b1;
        exp_waddr = wb_rd;
        exp_wdata = wb_mem_to_reg ? wb_read_data : wb_alu_res;
        foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        exp_we = e.live;
        if (e.live) begin
          exp_waddr = e.rd;
          exp_wdata = e.data;
        end
      end else begin
        exp_we = 1'b0;
      end
      if (accept) begin
        e.live = 1'b1;
        e.rd   = mdu_rd;
        e.data = mdu_data;
        mq.push_back(e);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      check_output("cyc_rf_we", 32'(rf_we), 32'(exp_we));
      if (exp_we) begin
        check_output("cyc_rf_waddr", 32'(rf_waddr), 32'(exp_waddr));
        check_output("cyc_rf_wdata", rf_wdata, exp_wdata);
      end
      check_output("cyc_q_count", 32'(q_count), 32'(mq.size()));
      check_output("cyc_mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
      check_output("cyc_pipe_stall", 32'(pipe_stall), 32'(mq.size() == DEPTH));
      check_output("cyc_pend_hit", 32'(pend_hit), 32'(model_pend(chk_rs, chk_rt)));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic m2r, input logic [4:0] rd,
                                input logic [31:0] rdata, input logic [31:0] alu,
                                input logic mv, input logic [4:0] mrd,
                                input logic [31:0] mdata);
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_rd         = rd;
    wb_read_data  = rdata;
    wb_alu_res    = alu;
    mdu_valid     = mv;
    mdu_rd        = mrd;
    mdu_data      = mdata;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    idle();
    #2;
    check_output("rst_rf_we", 32'(rf_we), 32'd0);
    check_output("rst_q_count", 32'(q_count), 32'd0);
    check_output("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check_output("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check_output("rst_pend_hit", 32'(pend_hit), 32'd0);
    #10 reset = 1'b0;
    cycle();

    // WB only: load data, then rd=0, then ALU path
    apply_stimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h11111111, 1'b0, 5'd0, 32'd0);
    cycle(); idle();
    check_output("wb_we", 32'(rf_we), 32'd1);
    check_output("wb_waddr", 32'(rf_waddr), 32'd5);
    check_output("wb_wdata", rf_wdata, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 32'h11111111, 1'b0, 5'd0, 32'd0);
    cycle(); idle();
    check_output("wb_rd0_we", 32'(rf_we), 32'd0);
    apply_stimulus(1'b1, 1'b0, 5'd6, 32'hDEADBEEF, 32'hA5A5_0F0F, 1'b0, 5'd0, 32'd0);
    cycle(); idle();
    check_output("wb_alu_wdata", rf_wdata, 32'hA5A5_0F0F);

    // MDU on an idle port: buffered one cycle, then written
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9, 32'h12345678);
    cycle(); idle();
    check_output("mdu_q1", 32'(q_count), 32'd1);
    check_output("mdu_no_bypass", 32'(rf_we), 32'd0);
    cycle();
    check_output("mdu_we", 32'(rf_we), 32'd1);
    check_output("mdu_waddr", 32'(rf_waddr), 32'd9);
    check_output("mdu_wdata", rf_wdata, 32'h12345678);
    check_output("mdu_q0", 32'(q_count), 32'd0);

    // MDU result to r0 is dropped
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF0000);
    cycle(); idle();
    check_output("mdu_r0_q", 32'(q_count), 32'd0);
    cycle();

    // Contention and fill
    apply_stimulus(1'b1, 1'b0, 5'd1, 32'd0, 32'h0000_1001, 1'b1, 5'd20, 32'h100);
    cycle();
    apply_stimulus(1'b1, 1'b0, 5'd2, 32'd0, 32'h0000_1002, 1'b1, 5'd21, 32'h101);
    cycle();
    apply_stimulus(1'b1, 1'b0, 5'd3, 32'd0, 32'h0000_1003, 1'b1, 5'd22, 32'h102);
    check_output("full_ready", 32'(mdu_ready), 32'd0);
    check_output("full_stall", 32'(pipe_stall), 32'd1);
    check_output("full_q", 32'(q_count), 32'd2);
    cycle();
    check_output("full_hold_q", 32'(q_count), 32'd2);
    wb_reg_write = 1'b0;
    cycle();
    check_output("drain1_waddr", 32'(rf_waddr), 32'd20);
    check_output("drain1_wdata", rf_wdata, 32'h100);
    check_output("drain1_stall", 32'(pipe_stall), 32'd0);
    cycle();
    mdu_valid = 1'b0;
    check_output("drain2_waddr", 32'(rf_waddr), 32'd21);
    check_output("drain2_q", 32'(q_count), 32'd1);
    cycle(); idle();
    check_output("drain3_waddr", 32'(rf_waddr), 32'd22);
    check_output("drain3_wdata", rf_wdata, 32'h102);
    check_output("drain3_q", 32'(q_count), 32'd0);

    // WAW kill of a buffered entry
    apply_stimulus(1'b1, 1'b0, 5'd2, 32'd0, 32'h22, 1'b1, 5'd7, 32'h77);
    chk_rs = 5'd7;
    cycle();
    check_output("kill_pend_before", 32'(pend_hit), 32'd1);
    apply_stimulus(1'b1, 1'b0, 5'd7, 32'd0, 32'h7070, 1'b0, 5'd0, 32'd0);
    cycle(); idle();
    check_output("kill_pend_after", 32'(pend_hit), 32'd0);
    check_output("kill_q", 32'(q_count), 32'd1);
    cycle();
    check_output("kill_pop_we", 32'(rf_we), 32'd0);
    check_output("kill_pop_q", 32'(q_count), 32'd0);

    // Same-cycle push is younger than the WB write and survives
    apply_stimulus(1'b1, 1'b0, 5'd8, 32'd0, 32'h8080, 1'b1, 5'd8, 32'h88);
    chk_rs = 5'd8;
    cycle(); idle();
    check_output("young_pend", 32'(pend_hit), 32'd1);
    cycle();
    check_output("young_we", 32'(rf_we), 32'd1);
    check_output("young_wdata", rf_wdata, 32'h88);

    // Hazard check with two buffered entries, then async reset
    apply_stimulus(1'b1, 1'b0, 5'd1, 32'd0, 32'h1, 1'b1, 5'd3, 32'h33);
    cycle();
    apply_stimulus(1'b1, 1'b0, 5'd1, 32'd0, 32'h1, 1'b1, 5'd4, 32'h44);
    cycle();
    mdu_valid = 1'b0;
    chk_rs = 5'd4; chk_rt = 5'd10;
    #1 check_output("haz_hit", 32'(pend_hit), 32'd1);
    chk_rs = 5'd0; chk_rt = 5'd11;
    #1 check_output("haz_miss", 32'(pend_hit), 32'd0);
    chk_rs = 5'd3;
    #1 check_output("haz_hit_rs3", 32'(pend_hit), 32'd1);
    reset = 1'b1;
    #1;
    check_output("arst_q", 32'(q_count), 32'd0);
    check_output("arst_ready", 32'(mdu_ready), 32'd1);
    check_output("arst_we", 32'(rf_we), 32'd0);
    check_output("arst_pend", 32'(pend_hit), 32'd0);
    idle();
    #3 reset = 1'b0;
    repeat (3) cycle();
    check_output("post_rst_we", 32'(rf_we), 32'd0);
    check_output("post_rst_q", 32'(q_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
